// File: rtl/rv32_mc_ctrl_if.sv
// Control/memory handshake bundle between the multi-cycle control FSM
// (master) and the shared datapath plus instruction/data memory ports (slave).
interface rv32_mc_ctrl_if;
  // Instruction memory port
  logic        imem_req;
  logic        imem_ready;
  // Datapath status
  logic [31:0] ir;
  logic        br_taken;
  // Data memory port
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  // Datapath enables and mux selects
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  // Status
  logic        retire;
  logic        trap;

  modport master (
    output imem_req,
    input  imem_ready,
    input  ir,
    input  br_taken,
    output dmem_req,
    output dmem_we,
    input  dmem_ready,
    output ir_we,
    output pc_we,
    output pc_sel,
    output alu_a_sel,
    output alu_b_sel,
    output rf_we,
    output wb_sel,
    output retire,
    output trap
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output ir,
    output br_taken,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready,
    input  ir_we,
    input  pc_we,
    input  pc_sel,
    input  alu_a_sel,
    input  alu_b_sel,
    input  rf_we,
    input  wb_sel,
    input  retire,
    input  trap
  );
endinterface

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// One instruction in flight; all datapath enables and mux selects come from
// the registered state and the opcode/funct3 fields of the latched IR.
// Illegal encodings park the FSM in HALT with a sticky trap until reset.
module rv32_mc_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  rv32_mc_ctrl_if.master bus
);

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  // PC source selects
  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_ALU     = 2'd1;
  localparam logic [1:0] PC_ALU_JR  = 2'd2;

  // Write-back source selects
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_LOAD    = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Instruction classes that share one sequencing path through the FSM
  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,  // OP, OP-IMM, LUI, AUIPC
    CL_JAL     = 3'd1,
    CL_JALR    = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_LOAD    = 3'd4,
    CL_STORE   = 3'd5,
    CL_FENCE   = 3'd6,
    CL_ILLEGAL = 3'd7
  } iclass_e;

  // Map opcode/funct3 to a sequencing class; anything outside RV32I
  // (including SYSTEM and compressed encodings) is illegal.
  function automatic iclass_e classify(input logic [6:0] opcode,
                                       input logic [2:0] funct3);
    iclass_e cls;
    cls = CL_ILLEGAL;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: cls = CL_ALU;
      OPC_JAL:    cls = CL_JAL;
      OPC_JALR:   cls = (funct3 == 3'b000) ? CL_JALR : CL_ILLEGAL;
      OPC_BRANCH: cls = ((funct3 == 3'b010) || (funct3 == 3'b011)) ? CL_ILLEGAL : CL_BRANCH;
      OPC_LOAD:   cls = ((funct3 == 3'b011) || (funct3 >= 3'b110)) ? CL_ILLEGAL : CL_LOAD;
      OPC_STORE:  cls = (funct3 >= 3'b011) ? CL_ILLEGAL : CL_STORE;
      OPC_MISC:   cls = CL_FENCE;
      default:    cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

  state_e     state_q;
  state_e     state_d;
  iclass_e    cls_s;
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       use_pc_a_s;
  logic       use_rs2_b_s;

  logic       imem_req_s;
  logic       ir_we_s;
  logic       dmem_req_s;
  logic       dmem_we_s;
  logic       pc_we_s;
  logic [1:0] pc_sel_s;
  logic       alu_a_sel_s;
  logic       alu_b_sel_s;
  logic       rf_we_s;
  logic [1:0] wb_sel_s;
  logic       retire_s;
  logic       trap_s;

  assign opcode_s    = bus.ir[6:0];
  assign funct3_s    = bus.ir[14:12];
  assign cls_s       = classify(opcode_s, funct3_s);
  // Operand A is the PC for PC-relative targets, operand B is rs2 only for
  // register-register ALU ops and branch compares.
  assign use_pc_a_s  = (opcode_s == OPC_AUIPC) || (opcode_s == OPC_JAL) ||
                       (opcode_s == OPC_BRANCH);
  assign use_rs2_b_s = (opcode_s == OPC_OP) || (opcode_s == OPC_BRANCH);

  // State register; reset lands directly in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d     = state_q;
    imem_req_s  = 1'b0;
    ir_we_s     = 1'b0;
    dmem_req_s  = 1'b0;
    dmem_we_s   = 1'b0;
    pc_we_s     = 1'b0;
    pc_sel_s    = PC_PLUS4;
    alu_a_sel_s = 1'b0;
    alu_b_sel_s = 1'b0;
    rf_we_s     = 1'b0;
    wb_sel_s    = WB_ALU;
    retire_s    = 1'b0;
    trap_s      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // The state register already sits in FETCH while reset is held;
        // keep the request quiet until reset is released.
        if (rst_n) begin
          imem_req_s = 1'b1;
          if (bus.imem_ready) begin
            ir_we_s = 1'b1;
            state_d = ST_DECODE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (cls_s == CL_ILLEGAL) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_a_sel_s = use_pc_a_s;
        alu_b_sel_s = !use_rs2_b_s;
        case (cls_s)
          CL_BRANCH: begin
            pc_we_s  = 1'b1;
            pc_sel_s = bus.br_taken ? PC_ALU : PC_PLUS4;
            retire_s = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_FENCE: begin
            pc_we_s  = 1'b1;
            pc_sel_s = PC_PLUS4;
            retire_s = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_ALU, CL_JAL, CL_JALR: state_d = ST_WB;
          default: state_d = ST_HALT;
        endcase
      end

      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (cls_s == CL_STORE);
        if (bus.dmem_ready) begin
          if (cls_s == CL_STORE) begin
            // A store has nothing to write back and completes here
            pc_we_s  = 1'b1;
            pc_sel_s = PC_PLUS4;
            retire_s = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_WB: begin
        rf_we_s  = 1'b1;
        pc_we_s  = 1'b1;
        retire_s = 1'b1;
        state_d  = ST_FETCH;
        case (cls_s)
          CL_LOAD: begin
            wb_sel_s = WB_LOAD;
            pc_sel_s = PC_PLUS4;
          end
          CL_JAL: begin
            wb_sel_s = WB_PC4;
            pc_sel_s = PC_ALU;
          end
          CL_JALR: begin
            wb_sel_s = WB_PC4;
            pc_sel_s = PC_ALU_JR;
          end
          default: begin
            wb_sel_s = WB_ALU;
            pc_sel_s = PC_PLUS4;
          end
        endcase
      end

      ST_HALT: begin
        // Absorbing until reset; every control stays low except trap
        trap_s  = 1'b1;
        state_d = ST_HALT;
      end

      default: begin
        trap_s  = 1'b1;
        state_d = ST_HALT;
      end
    endcase
  end

  assign bus.imem_req  = imem_req_s;
  assign bus.ir_we     = ir_we_s;
  assign bus.dmem_req  = dmem_req_s;
  assign bus.dmem_we   = dmem_we_s;
  assign bus.pc_we     = pc_we_s;
  assign bus.pc_sel    = pc_sel_s;
  assign bus.alu_a_sel = alu_a_sel_s;
  assign bus.alu_b_sel = alu_b_sel_s;
  assign bus.rf_we     = rf_we_s;
  assign bus.wb_sel    = wb_sel_s;
  assign bus.retire    = retire_s;
  assign bus.trap      = trap_s;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Bench for rv32_mc_ctrl. Each program is expanded from the instruction-level
// cycle rules into a per-cycle table of stimulus and expected outputs; one
// player drives the table and compares every cycle.
module tb_rv32_mc_ctrl;

  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_MISC   = 7'b0001111;
  localparam logic [6:0] O_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       trap;
  } out_t;

  typedef struct packed {
    logic        imr;
    logic        dmr;
    logic        bt;
    logic [31:0] ir;
  } stim_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  out_t        exp_q[$];
  stim_t       stim_q[$];
  logic [31:0] prev_ir;

  rv32_mc_ctrl_if bus();

  rv32_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Legal funct3 values per opcode, as an 8-bit mask indexed by funct3
  function automatic bit is_legal(input logic [31:0] w);
    logic [7:0] mask;
    case (w[6:0])
      O_JALR:   mask = 8'b0000_0001;
      O_BRANCH: mask = 8'b1111_0011;
      O_LOAD:   mask = 8'b0011_0111;
      O_STORE:  mask = 8'b0000_0111;
      O_LUI, O_AUIPC, O_JAL, O_OPIMM, O_OP, O_MISC: mask = 8'hFF;
      default:  mask = 8'h00;
    endcase
    return mask[w[14:12]];
  endfunction

  function automatic out_t sample();
    out_t a;
    a.imem_req  = bus.imem_req;
    a.ir_we     = bus.ir_we;
    a.dmem_req  = bus.dmem_req;
    a.dmem_we   = bus.dmem_we;
    a.pc_we     = bus.pc_we;
    a.pc_sel    = bus.pc_sel;
    a.alu_a_sel = bus.alu_a_sel;
    a.alu_b_sel = bus.alu_b_sel;
    a.rf_we     = bus.rf_we;
    a.wb_sel    = bus.wb_sel;
    a.retire    = bus.retire;
    a.trap      = bus.trap;
    return a;
  endfunction

  // Random levels on inputs the current cycle should ignore
  function automatic stim_t noise(input logic [31:0] ir);
    stim_t s;
    s.imr = 1'($urandom_range(0, 1));
    s.dmr = 1'($urandom_range(0, 1));
    s.bt  = 1'($urandom_range(0, 1));
    s.ir  = ir;
    return s;
  endfunction

  task automatic push(input stim_t s, input out_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Expand one instruction into its cycle-by-cycle expectations
  task automatic add_instr(input logic [31:0] w, input int wf, input int wm,
                           input logic taken, output int ncyc, output bit halted);
    stim_t s;
    out_t  e;
    logic [6:0] op;
    op     = w[6:0];
    ncyc   = 0;
    halted = 1'b0;
    for (int i = 0; i < wf; i++) begin
      s = noise(prev_ir); s.imr = 1'b0;
      e = '0; e.imem_req = 1'b1;
      push(s, e); ncyc++;
    end
    s = noise(prev_ir); s.imr = 1'b1;
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    push(s, e); ncyc++;
    prev_ir = w;
    s = noise(w); e = '0;
    push(s, e); ncyc++;
    if (!is_legal(w)) begin
      halted = 1'b1;
      return;
    end
    s = noise(w); e = '0;
    e.alu_a_sel = (op == O_AUIPC) || (op == O_JAL) || (op == O_BRANCH);
    e.alu_b_sel = !((op == O_OP) || (op == O_BRANCH));
    if (op == O_BRANCH) begin
      s.bt = taken;
      e.pc_we = 1'b1; e.pc_sel = taken ? 2'd1 : 2'd0; e.retire = 1'b1;
      push(s, e); ncyc++;
    end else if (op == O_MISC) begin
      e.pc_we = 1'b1; e.retire = 1'b1;
      push(s, e); ncyc++;
    end else begin
      push(s, e); ncyc++;
      if ((op == O_LOAD) || (op == O_STORE)) begin
        for (int i = 0; i < wm; i++) begin
          s = noise(w); s.dmr = 1'b0;
          e = '0; e.dmem_req = 1'b1; e.dmem_we = (op == O_STORE);
          push(s, e); ncyc++;
        end
        s = noise(w); s.dmr = 1'b1;
        e = '0; e.dmem_req = 1'b1; e.dmem_we = (op == O_STORE);
        if (op == O_STORE) begin
          e.pc_we = 1'b1; e.retire = 1'b1;
        end
        push(s, e); ncyc++;
      end
      if (op != O_STORE) begin
        s = noise(w);
        e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        if (op == O_LOAD)      e.wb_sel = 2'd1;
        else if ((op == O_JAL) || (op == O_JALR)) e.wb_sel = 2'd2;
        if (op == O_JAL)       e.pc_sel = 2'd1;
        else if (op == O_JALR) e.pc_sel = 2'd2;
        push(s, e); ncyc++;
      end
    end
  endtask

  task automatic add_halt(input int n);
    stim_t s;
    out_t  e;
    for (int i = 0; i < n; i++) begin
      s = noise($urandom());
      e = '0; e.trap = 1'b1;
      push(s, e);
    end
  endtask

  // Drive the table; called and returns at posedge+1
  task automatic play();
    stim_t s;
    out_t  e;
    out_t  a;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      bus.imem_ready = s.imr;
      bus.dmem_ready = s.dmr;
      bus.br_taken   = s.bt;
      bus.ir         = s.ir;
      @(negedge clk);
      a = sample();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_cmp[%0d] got=%b want=%b (req,irwe,dreq,dwe,pcwe,pcsel,a,b,rfwe,wbsel,ret,trap)",
                 cyc, a, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // Drop reset mid-cycle, check outputs clear at once, release at posedge+1
  task automatic do_reset();
    rst_n          = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    bus.ir         = 32'h0000_0000;
    prev_ir        = 32'h0000_0000;
    #1;
    checks++;
    if (sample() !== out_t'(0)) begin
      failures++;
      $display("FAIL reset_immediate got=%b want=0", sample());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample() !== out_t'(0)) begin
      failures++;
      $display("FAIL reset_hold got=%b want=0", sample());
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom();
    if ($urandom_range(0, 19) != 0) begin
      k = $urandom_range(0, 10);
      case (k)
        0:  w[6:0] = O_LUI;
        1:  w[6:0] = O_AUIPC;
        2:  w[6:0] = O_JAL;
        3:  w[6:0] = O_JALR;
        4:  w[6:0] = O_BRANCH;
        5:  w[6:0] = O_LOAD;
        6:  w[6:0] = O_STORE;
        7:  w[6:0] = O_OPIMM;
        8:  w[6:0] = O_OP;
        9:  w[6:0] = O_MISC;
        default: w[6:0] = O_SYSTEM;
      endcase
      if (!is_legal(w) && ($urandom_range(0, 3) != 0)) w[14:12] = 3'b000;
    end
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit h;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    bus.ir         = 32'h0000_0000;
    prev_ir        = 32'h0000_0000;
    @(posedge clk); #1;
    do_reset();

    // Fetch stalled for three cycles, then reset lands mid-request
    for (int i = 0; i < 3; i++) begin
      stim_t s;
      out_t e;
      s = noise(prev_ir); s.imr = 1'b0;
      e = '0; e.imem_req = 1'b1;
      push(s, e);
    end
    play();
    checks++;
    if (bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_req got=%b want=1", bus.imem_req);
    end
    do_reset();

    // Directed program; cycle counts pinned to hand-computed values
    add_instr(32'h0050_0093, 0, 0, 1'b0, n, h); pin("addi_cycles", n, 4);
    pin("addi_retire_last", int'(exp_q[$].retire), 1);
    add_instr(32'h0000_A103, 0, 2, 1'b0, n, h); pin("lw_wait2_cycles", n, 7);
    add_instr(32'h0020_8463, 0, 0, 1'b1, n, h); pin("beq_taken_cycles", n, 3);
    pin("beq_taken_pcsel", int'(exp_q[$].pc_sel), 1);
    add_instr(32'h0020_8463, 0, 0, 1'b0, n, h); pin("beq_nt_cycles", n, 3);
    add_instr(32'h0000_80E7, 0, 0, 1'b0, n, h); pin("jalr_cycles", n, 4);
    pin("jalr_pcsel", int'(exp_q[$].pc_sel), 2);
    add_instr(32'h0020_A023, 0, 0, 1'b0, n, h); pin("sw_cycles", n, 4);
    add_instr(32'h0000_000F, 0, 0, 1'b0, n, h); pin("fence_cycles", n, 3);
    add_instr(32'h0080_00EF, 1, 0, 1'b0, n, h); pin("jal_wait1_cycles", n, 5);
    add_instr(32'h1234_50B7, 2, 0, 1'b0, n, h);
    add_instr(32'h0000_1097, 0, 0, 1'b0, n, h);
    add_instr(32'h0020_81B3, 1, 0, 1'b0, n, h);
    add_instr(32'h0020_A023, 0, 3, 1'b0, n, h); pin("sw_wait3_cycles", n, 7);
    add_instr(32'h0000_90E7, 0, 0, 1'b0, n, h);
    pin("jalr_f3_illegal", int'(h), 1);
    pin("jalr_f3_illegal_cycles", n, 2);
    add_halt(6);
    play();

    // ECALL and the all-zero word both halt
    do_reset();
    add_instr(32'h0000_0073, 0, 0, 1'b0, n, h); pin("ecall_illegal", int'(h), 1);
    add_halt(4);
    play();
    do_reset();
    add_instr(32'h0000_0000, 1, 0, 1'b0, n, h); pin("zero_illegal", int'(h), 1);
    add_halt(4);
    play();

    // Randomized programs with random wait states
    for (int p = 0; p < 40; p++) begin
      do_reset();
      h = 1'b0;
      for (int k = 0; (k < 30) && !h; k++) begin
        add_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), n, h);
      end
      if (h) add_halt(3);
      play();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_mc_ctrl.md
# rv32_mc_ctrl

Multi-cycle control FSM for the RV32I core. Sequences instruction fetch, field decode, execute, data-memory access and register write-back. Drives every enable and mux select of the shared datapath (PC, IR, register file, ALU operand muxes, write-back mux) from the opcode/funct3 fields of the latched instruction. Sits between the two memory ports and the datapath; one instruction in flight at a time.

## Interface
- No parameters. Reset PC is owned by the datapath.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high until accepted
- imem_ready  in  1  fetch accepted, IR data valid this cycle
- ir  in  32  current instruction register contents (datapath IR)
- br_taken  in  1  branch condition from ALU compare, valid in EXEC
- dmem_req  out  1  data request; held high until accepted
- dmem_we  out  1  data write (store) qualifier for dmem_req
- dmem_ready  in  1  data access accepted; load data valid this cycle
- ir_we  out  1  latch fetched word into IR
- pc_we  out  1  update PC
- pc_sel  out  2  0 PC+4, 1 ALU result (branch/JAL target), 2 ALU result & ~1 (JALR)
- alu_a_sel  out  1  0 rs1, 1 PC
- alu_b_sel  out  1  0 rs2, 1 immediate
- rf_we  out  1  register-file write enable (datapath suppresses rd==0)
- wb_sel  out  2  0 ALU, 1 load data, 2 PC+4
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky; illegal instruction detected, core halted

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1. On imem_ready: ir_we=1, go DECODE. Otherwise stay, imem_req held.
- DECODE: decode ir[6:0]. instr[1:0]!=2'b11 or opcode not in RV32I set -> HALT. SYSTEM (1110011) -> HALT. Otherwise EXEC.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111 (FENCE = no-op).
- Additional illegal: JALR funct3!=0; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>=011.
- EXEC selects: alu_a_sel=1 for AUIPC, JAL, BRANCH; else 0. alu_b_sel=0 for OP, BRANCH; else 1 (LUI: datapath ALU passes imm).
- EXEC transitions:
  - OP, OP-IMM, LUI, AUIPC -> WB (wb_sel=0).
  - JAL/JALR -> WB (wb_sel=2); PC written in WB, pc_sel=1/2.
  - BRANCH: pc_we=1 in EXEC; pc_sel=1 if br_taken else 0; retire=1; -> FETCH.
  - FENCE: pc_we=1, pc_sel=0, retire=1 -> FETCH.
  - LOAD/STORE -> MEM.
- MEM: dmem_req=1, dmem_we=1 for STORE. Hold until dmem_ready. LOAD -> WB (wb_sel=1). STORE: pc_we=1, pc_sel=0, retire=1 -> FETCH.
- WB: rf_we=1; pc_we=1 (pc_sel=0 except JAL/JALR); retire=1 -> FETCH.
- HALT: trap=1, all other outputs 0, absorbing until rst_n low.
- Outputs are Moore/Mealy on registered state + ir; no output depends combinationally on imem_ready except ir_we, nor on dmem_ready except the MEM-state pc_we/retire.

## Timing
- Reset (rst_n low, any time, including mid-request): state=FETCH immediately; trap=0; every enable, dmem_req, retire = 0. imem_req rises the first cycle after rst_n high (FETCH).
- An abandoned memory request is never re-issued on its own; after reset, fetch restarts from reset PC.
- Cycle counts with zero-wait memory (ready in first request cycle): BRANCH/FENCE 3; ALU/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5. Each wait cycle adds one.
- Request stability: imem_req/dmem_req/dmem_we never drop before ready; never asserted in any other state.
- retire is exactly one cycle per completed instruction, coincident with its final pc_we.
- Illegal detection: DECODE cycle; trap high from the next cycle, no pc_we/rf_we for that instruction.

## Test plan
- Reset mid-fetch: drop rst_n while imem_req=1, imem_ready=0 -> all outputs 0 same cycle; after release, imem_req=1 next cycle, trap=0.
- ADDI (0x00500093), zero-wait -> ir_we cycle 1, rf_we+pc_we(pc_sel=0)+retire cycle 4, wb_sel=0, alu_b_sel=1.
- LW (0x0000A103) with dmem_ready delayed 2 cycles -> dmem_req held 3 cycles, dmem_we=0, rf_we with wb_sel=1, retire at cycle 7.
- BEQ taken and not taken (0x00208463) -> cycle 3 pc_we=1, pc_sel=1 vs 0, rf_we never set.
- JALR (0x000080E7) -> WB: rf_we=1, wb_sel=2, pc_sel=2; then illegal JALR funct3=1 (0x000090E7) -> trap=1 sticky, no further imem_req.
- ECALL (0x00000073) and word 0x00000000 -> each enters HALT, trap=1, retire never pulses.
